dmem_mmio: RTL and testbench

DMEM_MMIO -- requirements
Module: dmem_mmio

---
 rtl/dmem_mmio.sv | 189 ++++++++++++++++++
 tb/tb_dmem_mmio.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data memory plus memory-mapped I/O for a small core: word RAM, LED register,
// free-running timer and a transmit-only UART (8N1) with busy/overrun status.
module dmem_mmio #(
    parameter int RAM_WORDS    = 64,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic [7:0]  led,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Core handshake: there is no valid/ready pair. A store is the single-cycle
    // strobe dmem_we sampled at the rising edge; loads are combinational and
    // always complete in the same cycle, independent of dmem_we.

    logic [31:0]   mem [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          io_sel;
    logic [1:0]    io_reg;
    logic          wr_led;
    logic          wr_timer;
    logic          wr_tx;
    logic          wr_status;
    logic          unused_addr_bits;

    logic [31:0]   timer;
    logic          overrun;
    logic          busy;

    uart_state_t   state_q;
    uart_state_t   state_d;
    logic [BW-1:0] baud_q;
    logic [BW-1:0] baud_d;
    logic [2:0]    bit_q;
    logic [2:0]    bit_d;
    logic [7:0]    shift_q;
    logic [7:0]    shift_d;
    logic          tx_q;
    logic          tx_d;
    logic          baud_end;
    logic          tx_accept;

    assign ram_idx   = dmem_addr[AW+1:2];
    assign io_sel    = dmem_addr[31];
    assign io_reg    = dmem_addr[3:2];
    assign wr_led    = dmem_we && io_sel && (io_reg == 2'd0);
    assign wr_timer  = dmem_we && io_sel && (io_reg == 2'd1);
    assign wr_tx     = dmem_we && io_sel && (io_reg == 2'd2);
    assign wr_status = dmem_we && io_sel && (io_reg == 2'd3);
    assign unused_addr_bits = ^dmem_addr[30:0];

    // RAM ignores reset entirely, so a store coincident with reset still lands.
    always_ff @(posedge clk) begin
        if (dmem_we && !io_sel) begin
            mem[ram_idx] <= dmem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led     <= 8'd0;
            timer   <= 32'd0;
            overrun <= 1'b0;
        end else begin
            if (wr_led) begin
                led <= dmem_wdata[7:0];
            end
            if (wr_timer) begin
                timer <= dmem_wdata;
            end else begin
                timer <= timer + 32'd1;
            end
            if (wr_tx && busy) begin
                overrun <= 1'b1;
            end else if (wr_status) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign baud_end  = (baud_q == BAUD_LAST);
    assign tx_accept = wr_tx && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (tx_accept) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    shift_d = dmem_wdata[7:0];
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
    end

    assign uart_tx = tx_q;

    always_comb begin
        dmem_rdata = 32'd0;
        if (!io_sel) begin
            dmem_rdata = mem[ram_idx];
        end else begin
            case (io_reg)
                2'd0:    dmem_rdata = {24'd0, led};
                2'd1:    dmem_rdata = timer;
                2'd2:    dmem_rdata = 32'd0;
                default: dmem_rdata = {30'd0, overrun, busy};
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM aliasing, LED, timer wrap, UART framing,
// overrun handling and reset behaviour, with a fast baud setting.
module tb_dmem_mmio;

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_TIMER  = 32'h8000_0004;
    localparam logic [31:0] A_TX     = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;

    logic        clk;
    logic        reset;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic [7:0]  led;
    logic        uart_tx;

    int tests_run;
    int tests_failed;

    dmem_mmio #(.RAM_WORDS(64), .CLKS_PER_BIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .led        (led),
        .uart_tx    (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        dmem_we    = 1'b1;
        dmem_addr  = addr;
        dmem_wdata = data;
        tick();
        dmem_we    = 1'b0;
    endtask

    task automatic set_read(input logic [31:0] addr);
        dmem_we   = 1'b0;
        dmem_addr = addr;
        #1;
    endtask

    // Write already issued; we sit just after the edge that accepted it.
    task automatic check_frame(input string name, input logic [9:0] exp_bits);
        set_read(A_STATUS);
        for (int c = 0; c < 40; c++) begin
            tests_run++;
            if (uart_tx !== exp_bits[c/4]) begin
                tests_failed++;
                $display("FAIL %s tx cycle %0d: got %b exp %b", name, c, uart_tx, exp_bits[c/4]);
            end
            tests_run++;
            if (dmem_rdata !== 32'h1) begin
                tests_failed++;
                $display("FAIL %s busy cycle %0d: got %h exp %h", name, c, dmem_rdata, 32'h1);
            end
            tick();
        end
        tests_run++;
        if (uart_tx !== 1'b1 || dmem_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL %s end: got tx=%b status=%h exp tx=1 status=0", name, uart_tx, dmem_rdata);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        dmem_we    = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        tick();
        tick();
        tests_run++;
        if (led !== 8'h00 || uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_outputs: got led=%h tx=%b exp led=00 tx=1", led, uart_tx);
        end
        set_read(A_TIMER);
        tests_run++;
        if (dmem_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_timer: got %h exp %h", dmem_rdata, 32'h0);
        end
        set_read(A_STATUS);
        tests_run++;
        if (dmem_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_status: got %h exp %h", dmem_rdata, 32'h0);
        end
        do_write(A_LED, 32'hFF);
        tests_run++;
        if (led !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_led_write_ignored: got %h exp %h", led, 8'h00);
        end
        do_write(32'h0000_0020, 32'h1234_5678);
        reset = 1'b0;
        set_read(32'h0000_0020);
        tests_run++;
        if (dmem_rdata !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL reset_ram_write_kept: got %h exp %h", dmem_rdata, 32'h1234_5678);
        end
    endtask

    task automatic test_ram();
        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        do_write(32'h0000_0014, 32'hCAFE_F00D);
        set_read(32'h0000_0010);
        tests_run++;
        if (dmem_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL ram_read: got %h exp %h", dmem_rdata, 32'hDEAD_BEEF);
        end
        set_read(32'h0000_0110);
        tests_run++;
        if (dmem_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL ram_alias_110: got %h exp %h", dmem_rdata, 32'hDEAD_BEEF);
        end
        set_read(32'h7FFF_FF13);
        tests_run++;
        if (dmem_rdata !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL ram_alias_high: got %h exp %h", dmem_rdata, 32'hDEAD_BEEF);
        end
        set_read(32'h0000_0014);
        tests_run++;
        if (dmem_rdata !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL ram_second_word: got %h exp %h", dmem_rdata, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_led();
        do_write(A_LED, 32'h0000_01A5);
        tests_run++;
        if (led !== 8'hA5) begin
            tests_failed++;
            $display("FAIL led_port: got %h exp %h", led, 8'hA5);
        end
        set_read(A_LED);
        tests_run++;
        if (dmem_rdata !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL led_read: got %h exp %h", dmem_rdata, 32'h0000_00A5);
        end
        set_read(32'hFFFF_FFF0);
        tests_run++;
        if (dmem_rdata !== 32'h0000_00A5) begin
            tests_failed++;
            $display("FAIL led_read_alias: got %h exp %h", dmem_rdata, 32'h0000_00A5);
        end
        set_read(A_TX);
        tests_run++;
        if (dmem_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL txdata_read_zero: got %h exp %h", dmem_rdata, 32'h0);
        end
    endtask

    task automatic test_timer();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        set_read(A_TIMER);
        tests_run++;
        if (dmem_rdata !== 32'd10) begin
            tests_failed++;
            $display("FAIL timer_count: got %0d exp %0d", dmem_rdata, 10);
        end
        do_write(A_TIMER, 32'hFFFF_FFFE);
        set_read(A_TIMER);
        tests_run++;
        if (dmem_rdata !== 32'hFFFF_FFFE) begin
            tests_failed++;
            $display("FAIL timer_load: got %h exp %h", dmem_rdata, 32'hFFFF_FFFE);
        end
        tick();
        tick();
        tests_run++;
        if (dmem_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL timer_wrap: got %h exp %h", dmem_rdata, 32'h0);
        end
    endtask

    task automatic test_uart_frame();
        do_write(A_TX, 32'h55);
        check_frame("frame_55", 10'b1010101010);
    endtask

    task automatic test_overrun();
        logic [9:0] exp_bits;
        exp_bits = 10'b1010000010;
        do_write(A_TX, 32'h41);
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 2) begin
                tests_run++;
                if (uart_tx !== exp_bits[c/4]) begin
                    tests_failed++;
                    $display("FAIL overrun_tx cycle %0d: got %b exp %b", c, uart_tx, exp_bits[c/4]);
                end
            end
            if (c == 0) begin
                dmem_we    = 1'b1;
                dmem_addr  = A_TX;
                dmem_wdata = 32'h42;
            end else if (c == 1) begin
                set_read(A_STATUS);
                tests_run++;
                if (dmem_rdata !== 32'h3) begin
                    tests_failed++;
                    $display("FAIL overrun_status_set: got %h exp %h", dmem_rdata, 32'h3);
                end
                dmem_we    = 1'b1;
                dmem_wdata = 32'h0;
            end else if (c == 2) begin
                set_read(A_STATUS);
                tests_run++;
                if (dmem_rdata !== 32'h1) begin
                    tests_failed++;
                    $display("FAIL overrun_status_clear: got %h exp %h", dmem_rdata, 32'h1);
                end
            end
            tick();
        end
        set_read(A_STATUS);
        tests_run++;
        if (dmem_rdata !== 32'h0 || uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_end: got status=%h tx=%b exp status=0 tx=1", dmem_rdata, uart_tx);
        end
    endtask

    task automatic test_last_stop();
        do_write(A_TX, 32'h00);
        for (int c = 0; c < 39; c++) tick();
        do_write(A_TX, 32'h77);
        set_read(A_STATUS);
        tests_run++;
        if (dmem_rdata !== 32'h2 || uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL last_stop_drop: got status=%h tx=%b exp status=2 tx=1", dmem_rdata, uart_tx);
        end
        tick();
        tick();
        tests_run++;
        if (dmem_rdata !== 32'h2 || uart_tx !== 1'b1) begin
            tests_failed++;
            $display("FAIL last_stop_no_frame: got status=%h tx=%b exp status=2 tx=1", dmem_rdata, uart_tx);
        end
        do_write(A_STATUS, 32'h0);
        set_read(A_STATUS);
        tests_run++;
        if (dmem_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL last_stop_clear: got %h exp %h", dmem_rdata, 32'h0);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_write(A_TX, 32'hF7);
        for (int c = 0; c < 17; c++) tick();
        tests_run++;
        if (uart_tx !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_bit3: got %b exp %b", uart_tx, 1'b0);
        end
        reset = 1'b1;
        tick();
        set_read(A_STATUS);
        tests_run++;
        if (uart_tx !== 1'b1 || dmem_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL midframe_abort: got tx=%b status=%h exp tx=1 status=0", uart_tx, dmem_rdata);
        end
        reset = 1'b0;
        tick();
        do_write(A_TX, 32'hA5);
        check_frame("frame_after_reset", 10'b1101001010);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_ram();
        test_led();
        test_timer();
        test_uart_frame();
        test_overrun();
        test_last_stop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
